// File: rtl/word_tx_serializer.sv
// Captures one 32-bit word and emits it as four bytes over a valid/ready handshake.
// Optional WORD_TX_LITTLE_ENDIAN_EN sends the least-significant byte first.
module word_tx_serializer #(
  parameter int GAP_CYCLES_P = 0
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] data_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic [7:0]  data_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam bit          GAP_EN   = (GAP_CYCLES_P > 0);
  localparam logic [7:0]  GAP_LAST = GAP_EN ? 8'(GAP_CYCLES_P - 1) : 8'd0;

  state_e      state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  gap_q, gap_d;
  logic [7:0]  lane;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      // NOTE: the word register is reset too, so a discarded in-flight word
      // can never leak onto data_o after reset.
      word_q  <= 32'h0;
      idx_q   <= 2'd0;
      gap_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    // NOTE: every combinational output is defaulted first so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    unique case (state_q)
      IDLE: begin
        if (valid_i) begin
          state_d = SEND;
          word_d  = data_i;
          idx_d   = 2'd0;
          gap_d   = 8'd0;
        end
      end
      SEND: begin
        if (ready_i) begin
          if (idx_q == 2'd3) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 2'd1;
            gap_d   = 8'd0;
            state_d = GAP_EN ? GAP : SEND;
          end
        end
      end
      GAP: begin
        // ready_i has no effect here; the gap always runs to completion.
        if (gap_q == GAP_LAST) begin
          state_d = SEND;
          gap_d   = 8'd0;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lane = 8'h00;
    unique case (idx_q)
`ifdef WORD_TX_LITTLE_ENDIAN_EN
      2'd0: lane = word_q[7:0];
      2'd1: lane = word_q[15:8];
      2'd2: lane = word_q[23:16];
      2'd3: lane = word_q[31:24];
`else
      2'd0: lane = word_q[31:24];
      2'd1: lane = word_q[23:16];
      2'd2: lane = word_q[15:8];
      2'd3: lane = word_q[7:0];
`endif
      default: lane = 8'h00;
    endcase
  end

  // Outputs decode registered state only, so reset reaches them without a clock.
  assign ready_o = (state_q == IDLE);
  assign valid_o = (state_q == SEND);
  assign busy_o  = (state_q != IDLE);
  assign data_o  = (state_q == SEND) ? lane : 8'h00;

endmodule
